cc_speed_scheduler: RTL and testbench

Multi-lane speed scheduler for the Frogger playfield. It owns one up-counter per object lane. Each lane generates a one-cycle tick when its counter reaches all-ones, then reloads; this is the same terminal-count convention the speed comparator uses. The scheduler sequences the counters through idle/run/pause, applies per-lane reload values written by the game controller, and speeds every lane up with the game level. Lane ticks drive the car/log shift registers.

---
 rtl/cc_speed_pkg.sv | 31 +++
 rtl/cc_speed_lane.sv | 101 ++++++++++
 rtl/cc_speed_scheduler.sv | 121 ++++++++++++
 tb/tb_cc_speed_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_speed_pkg.sv
// -----------------------------------------------------------------------------
// cc_speed_pkg
// Shared definitions for the Frogger lane speed scheduler:
//   - scheduler state encoding (IDLE / RUN / PAUSE)
//   - default counter width, level shift, level width, lane count and reload
//   - saturation limit 2^W-2, which keeps the shortest lane period at 2 cycles
// No ports; imported by cc_speed_lane and cc_speed_scheduler.
// -----------------------------------------------------------------------------
package cc_speed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sched_state_e;

  localparam int DEFAULT_LANES       = 4;
  localparam int DEFAULT_W           = 15;
  localparam int DEFAULT_LEVEL_WIDTH = 3;
  localparam int DEFAULT_LEVEL_SHIFT = 9;
  localparam int DEFAULT_RELOAD      = 'h4000;

  // Largest effective reload for the default width (2^W-2).
  localparam logic [DEFAULT_W-1:0] DEFAULT_SAT_LIMIT = {{(DEFAULT_W-1){1'b1}}, 1'b0};

  // Saturation limit for an arbitrary counter width.
  function automatic int sat_limit(input int w);
    return (1 << w) - 2;
  endfunction

endpackage

// File: rtl/cc_speed_lane.sv
// -----------------------------------------------------------------------------
// cc_speed_lane
// One object lane of the speed scheduler. Holds the lane's reload register,
// an up-counter that wraps from all-ones back to the effective reload, and the
// registered one-cycle tick emitted on that wrap.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   hold        load the counter with the effective reload (IDLE or stop)
//   count_en    advance the counter this edge (RUN, pause low, no stop)
//   level       current game level, added (shifted) to the reload
//   cfg_we      write strobe for this lane's reload register
//   cfg_reload  value written on cfg_we (all-ones is clamped to 2^W-2)
//   tick        registered one-cycle tick at terminal count
// -----------------------------------------------------------------------------
module cc_speed_lane
  import cc_speed_pkg::*;
#(
  parameter int W              = DEFAULT_W,
  parameter int LEVEL_WIDTH    = DEFAULT_LEVEL_WIDTH,
  parameter int LEVEL_SHIFT    = DEFAULT_LEVEL_SHIFT,
  parameter int RELOAD_DEFAULT = DEFAULT_RELOAD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   count_en,
  input  logic [LEVEL_WIDTH-1:0] level,
  input  logic                   cfg_we,
  input  logic [W-1:0]           cfg_reload,
  output logic                   tick
);

  // Sum width wide enough that reload + (level << shift) can never wrap.
  localparam int SW = W + LEVEL_WIDTH + LEVEL_SHIFT;

  localparam logic [W-1:0] ALL_ONES    = {W{1'b1}};
  localparam logic [W-1:0] SAT_LIMIT   = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] RELOAD_INIT = RELOAD_DEFAULT[W-1:0];
  localparam logic [W-1:0] ONE         = {{(W-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] eff_of(input logic [W-1:0]           base,
                                          input logic [LEVEL_WIDTH-1:0] lvl);
    logic [SW-1:0] sum;
    sum = SW'(base) + (SW'(lvl) << LEVEL_SHIFT);
    if (sum > SW'(SAT_LIMIT)) begin
      return SAT_LIMIT;
    end
    return sum[W-1:0];
  endfunction

  logic [W-1:0] reload_q, reload_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;
  logic [W-1:0] eff;
  logic [W-1:0] eff_rst;
  logic         terminal;

  always_comb begin
    // eff always uses the register value from before this edge, so a write
    // landing on a terminal-count cycle only affects the following reload.
    eff      = eff_of(reload_q, level);
    eff_rst  = eff_of(RELOAD_INIT, level);
    terminal = (cnt_q == ALL_ONES);

    reload_d = reload_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;

    if (cfg_we) begin
      reload_d = (cfg_reload == ALL_ONES) ? SAT_LIMIT : cfg_reload;
    end

    if (hold) begin
      cnt_d = eff;
    end else if (count_en) begin
      if (terminal) begin
        cnt_d  = eff;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= RELOAD_INIT;
      cnt_q    <= eff_rst;
      tick_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/cc_speed_scheduler.sv
// -----------------------------------------------------------------------------
// cc_speed_scheduler
// Multi-lane speed scheduler for the Frogger playfield. Sequences LANES lane
// counters through IDLE / RUN / PAUSE, decodes reload writes to the target
// lane and fans out the hold / count controls. Lane ticks drive the car/log
// shift registers.
//
// Ports
//   CC_SPEEDSCHEDULER_CLOCK_50         system clock, rising edge
//   CC_SPEEDSCHEDULER_RESET_InHigh     synchronous active-high reset
//   CC_SPEEDSCHEDULER_start_InHigh     pulse, IDLE -> RUN
//   CC_SPEEDSCHEDULER_stop_InHigh      pulse, any state -> IDLE (highest priority)
//   CC_SPEEDSCHEDULER_pause_InHigh     level, holds RUN in PAUSE while high
//   CC_SPEEDSCHEDULER_level_InBUS      game level, speeds up all lanes
//   CC_SPEEDSCHEDULER_cfgWrite_InHigh  reload register write strobe
//   CC_SPEEDSCHEDULER_cfgLane_InBUS    target lane of the write
//   CC_SPEEDSCHEDULER_cfgReload_InBUS  reload value
//   CC_SPEEDSCHEDULER_tick_OutBUS      per-lane registered one-cycle tick
//   CC_SPEEDSCHEDULER_state_OutBUS     registered state: 0 IDLE, 1 RUN, 2 PAUSE
// -----------------------------------------------------------------------------
module cc_speed_scheduler
  import cc_speed_pkg::*;
#(
  parameter int LANES                    = DEFAULT_LANES,
  parameter int SPEEDSCHEDULER_DATAWIDTH = DEFAULT_W,
  parameter int LEVEL_WIDTH              = DEFAULT_LEVEL_WIDTH,
  parameter int LEVEL_SHIFT              = DEFAULT_LEVEL_SHIFT,
  parameter int RELOAD_DEFAULT           = DEFAULT_RELOAD
) (
  input  logic                                              CC_SPEEDSCHEDULER_CLOCK_50,
  input  logic                                              CC_SPEEDSCHEDULER_RESET_InHigh,
  input  logic                                              CC_SPEEDSCHEDULER_start_InHigh,
  input  logic                                              CC_SPEEDSCHEDULER_stop_InHigh,
  input  logic                                              CC_SPEEDSCHEDULER_pause_InHigh,
  input  logic [LEVEL_WIDTH-1:0]                            CC_SPEEDSCHEDULER_level_InBUS,
  input  logic                                              CC_SPEEDSCHEDULER_cfgWrite_InHigh,
  input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0]      CC_SPEEDSCHEDULER_cfgLane_InBUS,
  input  logic [SPEEDSCHEDULER_DATAWIDTH-1:0]               CC_SPEEDSCHEDULER_cfgReload_InBUS,
  output logic [LANES-1:0]                                  CC_SPEEDSCHEDULER_tick_OutBUS,
  output logic [1:0]                                        CC_SPEEDSCHEDULER_state_OutBUS
);

  localparam int LANE_AW = (LANES > 1) ? $clog2(LANES) : 1;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic pause;

  assign clk   = CC_SPEEDSCHEDULER_CLOCK_50;
  assign rst   = CC_SPEEDSCHEDULER_RESET_InHigh;
  assign start = CC_SPEEDSCHEDULER_start_InHigh;
  assign stop  = CC_SPEEDSCHEDULER_stop_InHigh;
  assign pause = CC_SPEEDSCHEDULER_pause_InHigh;

  sched_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start)  state_d = ST_RUN;
        ST_RUN:   if (pause)  state_d = ST_PAUSE;
        ST_PAUSE: if (!pause) state_d = ST_RUN;
        default:              state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign CC_SPEEDSCHEDULER_state_OutBUS = state_q;

  // Counting is gated by the pause input itself rather than the registered
  // state: the edge that sees pause rise is already inhibited, and the edge
  // that sees pause fall already counts, so a pause of N cycles delays the
  // next tick by exactly N.
  logic lane_hold;
  logic lane_count_en;

  assign lane_hold     = stop || (state_q == ST_IDLE);
  assign lane_count_en = !stop && !pause &&
                         ((state_q == ST_RUN) || (state_q == ST_PAUSE));

  // A lane index at or above LANES matches no instance, so such writes drop.
  logic [LANES-1:0] lane_we;
  logic [LANES-1:0] lane_tick;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_we[i] = CC_SPEEDSCHEDULER_cfgWrite_InHigh &&
                        (CC_SPEEDSCHEDULER_cfgLane_InBUS == LANE_AW'(i));

    cc_speed_lane #(
      .W              (SPEEDSCHEDULER_DATAWIDTH),
      .LEVEL_WIDTH    (LEVEL_WIDTH),
      .LEVEL_SHIFT    (LEVEL_SHIFT),
      .RELOAD_DEFAULT (RELOAD_DEFAULT)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .hold       (lane_hold),
      .count_en   (lane_count_en),
      .level      (CC_SPEEDSCHEDULER_level_InBUS),
      .cfg_we     (lane_we[i]),
      .cfg_reload (CC_SPEEDSCHEDULER_cfgReload_InBUS),
      .tick       (lane_tick[i])
    );
  end

  assign CC_SPEEDSCHEDULER_tick_OutBUS = lane_tick;

endmodule

// File: tb/tb_cc_speed_scheduler.sv
module tb_cc_speed_scheduler;

  localparam int LANES = 4;
  localparam int W     = 4;
  localparam int LW    = 3;
  localparam int LS    = 1;
  localparam int RDEF  = 8;
  localparam int MAXV  = (1 << W) - 1;
  localparam int SAT   = MAXV - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             pause = 1'b0;
  logic [LW-1:0]    level = '0;
  logic             we    = 1'b0;
  logic [1:0]       lane  = '0;
  logic [W-1:0]     data  = '0;
  logic [LANES-1:0] tick;
  logic [1:0]       state;

  cc_speed_scheduler #(
    .LANES                    (LANES),
    .SPEEDSCHEDULER_DATAWIDTH (W),
    .LEVEL_WIDTH              (LW),
    .LEVEL_SHIFT              (LS),
    .RELOAD_DEFAULT           (RDEF)
  ) dut (
    .CC_SPEEDSCHEDULER_CLOCK_50        (clk),
    .CC_SPEEDSCHEDULER_RESET_InHigh    (rst),
    .CC_SPEEDSCHEDULER_start_InHigh    (start),
    .CC_SPEEDSCHEDULER_stop_InHigh     (stop),
    .CC_SPEEDSCHEDULER_pause_InHigh    (pause),
    .CC_SPEEDSCHEDULER_level_InBUS     (level),
    .CC_SPEEDSCHEDULER_cfgWrite_InHigh (we),
    .CC_SPEEDSCHEDULER_cfgLane_InBUS   (lane),
    .CC_SPEEDSCHEDULER_cfgReload_InBUS (data),
    .CC_SPEEDSCHEDULER_tick_OutBUS     (tick),
    .CC_SPEEDSCHEDULER_state_OutBUS    (state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_valid = 0;
  int               m_state;
  int               m_reg [LANES];
  int               m_cnt [LANES];
  logic [LANES-1:0] m_tick;
  int               tick_times [LANES][$];

  function automatic int eff_of(input int r, input int lvl);
    int s;
    s = r + (lvl * (1 << LS));
    return (s > SAT) ? SAT : s;
  endfunction

  always @(posedge clk) begin
    logic r, s0, s1, p, w;
    int   lv, ln, dt;
    int   effv [LANES];
    cyc++;
    r = rst; s0 = start; s1 = stop; p = pause; w = we;
    lv = int'(level); ln = int'(lane); dt = int'(data);
    if (r) begin
      m_valid = 1;
      m_state = 0;
      m_tick  = '0;
      for (int i = 0; i < LANES; i++) begin
        m_reg[i] = RDEF;
        m_cnt[i] = eff_of(RDEF, lv);
      end
    end else if (m_valid) begin
      for (int i = 0; i < LANES; i++) effv[i] = eff_of(m_reg[i], lv);
      m_tick = '0;
      for (int i = 0; i < LANES; i++) begin
        if (s1 || m_state == 0) begin
          m_cnt[i] = effv[i];
        end else if (!p) begin
          if (m_cnt[i] == MAXV) begin
            m_cnt[i]  = effv[i];
            m_tick[i] = 1'b1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (w && ln < LANES) m_reg[ln] = (dt == MAXV) ? SAT : dt;
      if (s1)                        m_state = 0;
      else if (m_state == 0 && s0)   m_state = 1;
      else if (m_state == 1 && p)    m_state = 2;
      else if (m_state == 2 && !p)   m_state = 1;
    end
    if (m_valid) begin
      #1;
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_state", 32'(state), 32'(m_state));
      for (int i = 0; i < LANES; i++) if (tick[i] === 1'b1) tick_times[i].push_back(cyc);
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input bit s0, input bit s1, input bit p,
                      input bit w, input int ln, input int dt);
    @(negedge clk);
    start = s0; stop = s1; pause = p; we = w;
    lane = 2'(ln); data = W'(dt);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 0; stop = 0; pause = 0; we = 0;
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_ticks();
    for (int i = 0; i < LANES; i++) tick_times[i].delete();
  endtask

  function automatic int tt(input int ln, input int idx);
    if (idx < tick_times[ln].size()) return tick_times[ln][idx];
    return -1000;
  endfunction

  typedef struct packed {
    logic             s0;
    logic             s1;
    logic             p;
    logic [LANES-1:0] tick;
    logic [1:0]       st;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int k, k2, tl;

    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, tl;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'h0, 2'd2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 2'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'h0, 2'd0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'd1};
    for (int i = 11; i <= 17; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 4'hF, 2'd1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'd1};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 4'h0, 2'd0};

    // Reset state and table-driven FSM walk (default reload 8, level 0).
    do_reset();
    idle(1);
    check("reset_state", 32'(state), 0);
    check("reset_tick", 32'(tick), 0);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].s0, tbl[i].s1, tbl[i].p, 0, 0, 0);
      check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
    end

    // Lane0 reload 10 -> period 6; other lanes keep default period 8.
    do_reset();
    step(0, 0, 0, 1, 0, 10);
    idle(1);
    clear_ticks();
    step(1, 0, 0, 0, 0, 0);
    k = cyc;
    idle(20);
    check("p6_first", 32'(tt(0, 0) - k), 6);
    check("p6_period_a", 32'(tt(0, 1) - tt(0, 0)), 6);
    check("p6_period_b", 32'(tt(0, 2) - tt(0, 1)), 6);
    check("default_first", 32'(tt(1, 0) - k), 8);

    // Pause for 5 cycles mid-count: tick delayed by exactly 5.
    tl = tt(0, 2);
    clear_ticks();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 0);
      check("pause_state", 32'(state), 2);
      check("pause_tick", 32'(tick), 0);
    end
    idle(10);
    check("pause_delay", 32'(tt(0, 0) - tl), 11);

    // Level speed-up and saturation on lane1 (reload 10).
    do_reset();
    level = 3'd2;
    step(0, 0, 0, 1, 1, 10);
    idle(1);
    clear_ticks();
    step(1, 0, 0, 0, 0, 0);
    k = cyc;
    idle(10);
    check("lvl2_first", 32'(tt(1, 0) - k), 2);
    check("lvl2_period", 32'(tt(1, 1) - tt(1, 0)), 2);
    level = 3'd3;
    clear_ticks();
    idle(10);
    check("lvl3_sat_period", 32'(tt(1, 2) - tt(1, 1)), 2);
    check("lvl3_sat_count", 32'(tick_times[1].size()), 5);

    // Writing all-ones is clamped to 2^W-2 (period 2, not 1).
    level = 3'd0;
    step(0, 0, 0, 1, 3, 15);
    idle(6);
    clear_ticks();
    idle(8);
    check("clamp_period", 32'(tt(3, 1) - tt(3, 0)), 2);
    check("clamp_count", 32'(tick_times[3].size()), 4);

    // Write coincident with terminal count on lane2 (old 8, new 12).
    do_reset();
    step(0, 0, 0, 1, 2, 8);
    idle(1);
    clear_ticks();
    step(1, 0, 0, 0, 0, 0);
    k = cyc;
    while (cyc < k + 15) idle(1);
    step(0, 0, 0, 1, 2, 12);
    check("wr_tc_tick", 32'(tick[2]), 1);
    idle(20);
    check("wr_tc_old_period", 32'(tt(2, 2) - tt(2, 1)), 8);
    check("wr_tc_new_period_a", 32'(tt(2, 3) - tt(2, 2)), 4);
    check("wr_tc_new_period_b", 32'(tt(2, 4) - tt(2, 3)), 4);

    // stop and start together in RUN -> IDLE; later start gives full period.
    do_reset();
    step(0, 0, 0, 1, 0, 10);
    idle(1);
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    step(1, 1, 0, 0, 0, 0);
    check("stopstart_state", 32'(state), 0);
    check("stopstart_tick", 32'(tick), 0);
    idle(2);
    check("stopstart_hold", 32'(state), 0);
    clear_ticks();
    step(1, 0, 0, 0, 0, 0);
    k2 = cyc;
    idle(9);
    check("restart_lane0", 32'(tt(0, 0) - k2), 6);
    check("restart_lane1", 32'(tt(1, 0) - k2), 8);

    // Reset mid-run with lane3 counter at 13.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    k = cyc;
    while (cyc < k + 5) idle(1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("midrst_state", 32'(state), 0);
    check("midrst_tick", 32'(tick), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_ticks();
    step(1, 0, 0, 0, 0, 0);
    k2 = cyc;
    idle(10);
    check("midrst_lane3", 32'(tt(3, 0) - k2), 8);

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 5) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 9) == 0) level = LW'($urandom_range(0, 7));
      we    = ($urandom_range(0, 3) == 0);
      lane  = 2'($urandom_range(0, 3));
      data  = W'($urandom_range(0, 15));
      @(posedge clk);
      #2;
    end
    @(negedge clk);
    rst = 0; start = 0; stop = 0; pause = 0; we = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
